// File: rtl/cep_noc_deserializer.sv
// Assembles one NoC packet into a CEP field set; pkg_val rises the cycle after the last flit.
// Input stalls (noc_in_rdy=0) only in OUT, which lasts until the encoder takes the field set.
module cep_noc_deserializer #(
    parameter int REQ_CHANNEL    = 0,
    parameter int CEP_WORD_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        noc_in_val,
    input  logic [CEP_WORD_WIDTH-1:0]   noc_in_data,
    output logic                        noc_in_rdy,
    output logic                        pkg_val,
    input  logic                        pkg_rdy,
    output logic                        is_request,
    output logic [0:0]                  last_subline,
    output logic [1:0]                  subline_id,
    output logic [1:0]                  mesi,
    output logic [7:0]                  mshrid,
    output logic [7:0]                  msg_type,
    output logic [7:0]                  length,
    output logic [2:0]                  data_size,
    output logic [0:0]                  cache_type,
    output logic [47:0]                 addr,
    output logic [13:0]                 src_chipid,
    output logic [7*CEP_WORD_WIDTH-1:0] data,
    output logic                        overflow_err
);

    localparam bit         IS_REQ = (REQ_CHANNEL != 0);
    localparam logic [2:0] CAP    = IS_REQ ? 3'd5 : 3'd7;

    typedef enum logic [2:0] {
        HDR0    = 3'd0,
        HDR1    = 3'd1,
        HDR2    = 3'd2,
        PAYLOAD = 3'd3,
        DRAIN   = 3'd4,
        OUT     = 3'd5
    } state_t;

    state_t                      r_state;
    logic [7:0]                  r_rem;
    logic [2:0]                  r_widx;
    logic [0:0]                  r_last_subline;
    logic [1:0]                  r_subline_id;
    logic [1:0]                  r_mesi;
    logic [7:0]                  r_mshrid;
    logic [7:0]                  r_msg_type;
    logic [7:0]                  r_length;
    logic [2:0]                  r_data_size;
    logic [0:0]                  r_cache_type;
    logic [47:0]                 r_addr;
    logic [13:0]                 r_src_chipid;
    logic [7*CEP_WORD_WIDTH-1:0] r_data;
    logic                        r_overflow_err;

    logic       w_accept;
    logic [7:0] w_len;
    logic [7:0] w_rem_dec;
    logic [2:0] w_widx_inc;

    assign noc_in_rdy = (r_state != OUT);
    assign pkg_val    = (r_state == OUT);
    assign w_accept   = noc_in_val & noc_in_rdy;
    assign w_len      = noc_in_data[29:22];
    assign w_rem_dec  = r_rem - 8'd1;
    assign w_widx_inc = r_widx + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= HDR0;
            r_rem          <= '0;
            r_widx         <= '0;
            r_last_subline <= '0;
            r_subline_id   <= '0;
            r_mesi         <= '0;
            r_mshrid       <= '0;
            r_msg_type     <= '0;
            r_length       <= '0;
            r_data_size    <= '0;
            r_cache_type   <= '0;
            r_addr         <= '0;
            r_src_chipid   <= '0;
            r_data         <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            r_overflow_err <= 1'b0;
            case (r_state)
                HDR0: begin
                    if (w_accept) begin
                        r_length     <= w_len;
                        r_msg_type   <= noc_in_data[21:14];
                        r_mshrid     <= noc_in_data[13:6];
                        r_addr       <= '0;
                        r_cache_type <= '0;
                        r_src_chipid <= '0;
                        r_data_size  <= '0;
                        r_data       <= '0;
                        r_rem        <= w_len;
                        r_widx       <= '0;
                        if (IS_REQ) begin
                            r_mesi         <= '0;
                            r_last_subline <= '0;
                            r_subline_id   <= '0;
                            if (w_len != 8'd0) begin
                                r_state <= HDR1;
                            end else begin
                                r_state        <= OUT;
                                r_overflow_err <= 1'b1;
                            end
                        end else begin
                            r_mesi         <= noc_in_data[5:4];
                            r_last_subline <= noc_in_data[3:3];
                            r_subline_id   <= noc_in_data[2:1];
                            r_state        <= (w_len != 8'd0) ? PAYLOAD : OUT;
                        end
                    end
                end
                HDR1: begin
                    if (w_accept) begin
                        r_addr       <= noc_in_data[63:16];
                        r_cache_type <= noc_in_data[0:0];
                        r_rem        <= w_rem_dec;
                        if (w_rem_dec != 8'd0) begin
                            r_state <= HDR2;
                        end else begin
                            // Header cut short before the chip-id flit.
                            r_state        <= OUT;
                            r_overflow_err <= 1'b1;
                        end
                    end
                end
                HDR2: begin
                    if (w_accept) begin
                        r_src_chipid <= noc_in_data[63:50];
                        r_data_size  <= noc_in_data[15:13];
                        r_rem        <= w_rem_dec;
                        r_state      <= (w_rem_dec != 8'd0) ? PAYLOAD : OUT;
                    end
                end
                PAYLOAD: begin
                    if (w_accept) begin
                        for (int i = 0; i < 7; i++) begin
                            if (r_widx == 3'(i)) begin
                                r_data[i*CEP_WORD_WIDTH +: CEP_WORD_WIDTH] <= noc_in_data;
                            end
                        end
                        r_widx <= w_widx_inc;
                        r_rem  <= w_rem_dec;
                        if (w_rem_dec == 8'd0) begin
                            r_state <= OUT;
                        end else if (w_widx_inc == CAP) begin
                            r_state        <= DRAIN;
                            r_overflow_err <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_accept) begin
                        r_rem <= w_rem_dec;
                        if (w_rem_dec == 8'd0) begin
                            r_state <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (pkg_rdy) begin
                        r_state <= HDR0;
                    end
                end
                default: r_state <= HDR0;
            endcase
        end
    end

    assign is_request   = IS_REQ;
    assign last_subline = r_last_subline;
    assign subline_id   = r_subline_id;
    assign mesi         = r_mesi;
    assign mshrid       = r_mshrid;
    assign msg_type     = r_msg_type;
    assign length       = r_length;
    assign data_size    = r_data_size;
    assign cache_type   = r_cache_type;
    assign addr         = r_addr;
    assign src_chipid   = r_src_chipid;
    assign data         = r_data;
    assign overflow_err = r_overflow_err;

endmodule
